// File: rtl/acc_drain_buffer_pkg.sv
// Shared definitions for the accumulator drain buffer: width helpers,
// signed lane limits and the drain FSM state encoding.
package acc_drain_buffer_pkg;

  // Bits needed to represent value (minimum 1).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v = value;
    bits = 0;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

  function automatic longint lane_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint lane_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } drain_state_t;

endpackage

// File: rtl/acc_drain_buffer_if.sv
// Drain output stream: one requantised row per valid/ready handshake.
interface acc_drain_buffer_if #(
  parameter int DATA_NUM         = 16,
  parameter int OUTPUT_DATA_SIZE = 8
) ();
  logic [DATA_NUM*OUTPUT_DATA_SIZE-1:0] doutb;
  logic                                 dout_valid;
  logic                                 dout_ready;
  logic                                 dout_last;

  modport master (output doutb, output dout_valid, output dout_last, input dout_ready);
  modport slave  (input doutb, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/acc_requant_lane.sv
// One lane of requantisation: rounding arithmetic right shift, optional
// ReLU, then saturation to the output width. Purely combinational.
module acc_requant_lane
  import acc_drain_buffer_pkg::*;
#(
  parameter int DATA_SIZE        = 20,
  parameter int OUTPUT_DATA_SIZE = 8,
  parameter int SHIFT_W          = 5
) (
  input  logic signed [DATA_SIZE-1:0]        x,
  input  logic        [SHIFT_W-1:0]          s,
  input  logic                               relu,
  output logic signed [OUTPUT_DATA_SIZE-1:0] y
);

  localparam logic signed [DATA_SIZE:0] OUT_HI = (DATA_SIZE+1)'(lane_max(OUTPUT_DATA_SIZE));
  localparam logic signed [DATA_SIZE:0] OUT_LO = (DATA_SIZE+1)'(lane_min(OUTPUT_DATA_SIZE));

  logic signed [DATA_SIZE:0] ext;
  logic signed [DATA_SIZE:0] half;
  logic signed [DATA_SIZE:0] rounded;
  logic signed [DATA_SIZE:0] shifted;
  logic signed [DATA_SIZE:0] clamped;

  always_comb begin
    ext  = {x[DATA_SIZE-1], x};
    half = '0;
    // One extra bit keeps x + 2^(s-1) from overflowing for any s < DATA_SIZE.
    if (s != '0) half = (DATA_SIZE+1)'(1) << (s - SHIFT_W'(1));
    rounded = ext + half;
    shifted = rounded >>> s;
    clamped = shifted;
    if (relu && (shifted < 0)) clamped = '0;
    y = clamped[OUTPUT_DATA_SIZE-1:0];
    if (clamped > OUT_HI) y = OUT_HI[OUTPUT_DATA_SIZE-1:0];
    else if (clamped < OUT_LO) y = OUT_LO[OUTPUT_DATA_SIZE-1:0];
  end

endmodule

// File: rtl/acc_drain_buffer.sv
// Output accumulator with saturating accumulate/overwrite writes and a drain
// engine streaming a wrapping range of requantised rows over valid/ready.
module acc_drain_buffer
  import acc_drain_buffer_pkg::*;
#(
  parameter int DATA_SIZE        = 20,
  parameter int OUTPUT_DATA_SIZE = 8,
  parameter int DATA_NUM         = 16,
  parameter int RAM_DEPTH        = 16,
  parameter int SHIFT_W          = 5,
  parameter int ADDR_W           = clogb2(RAM_DEPTH - 1),
  parameter int LEN_W            = clogb2(RAM_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wea,
  input  logic                          acc_en,
  input  logic [ADDR_W-1:0]             addra,
  input  logic [DATA_NUM*DATA_SIZE-1:0] dina,
  input  logic                          drain_start,
  input  logic [ADDR_W-1:0]             drain_base,
  input  logic [LEN_W-1:0]              drain_len,
  input  logic [SHIFT_W-1:0]            shift_amt,
  input  logic                          relu_en,
  input  logic                          clear_en,
  acc_drain_buffer_if.master            dout,
  output logic                          busy,
  output logic                          drain_done
);

  localparam int ROW_W = DATA_NUM * DATA_SIZE;
  localparam int OUT_W = DATA_NUM * OUTPUT_DATA_SIZE;
  localparam logic [DATA_SIZE-1:0] ACC_HI = DATA_SIZE'(lane_max(DATA_SIZE));
  localparam logic [DATA_SIZE-1:0] ACC_LO = DATA_SIZE'(lane_min(DATA_SIZE));
  localparam logic [ADDR_W-1:0]    LAST_ROW = ADDR_W'(RAM_DEPTH - 1);

  logic [ROW_W-1:0] mem [RAM_DEPTH];

  drain_state_t     state_reg, state_next;
  logic [ADDR_W-1:0]  ptr_reg, ptr_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic [SHIFT_W-1:0] shift_reg, shift_next;
  logic               relu_reg, relu_next;
  logic               clear_reg, clear_next;
  logic [OUT_W-1:0]   dout_reg, dout_next;
  logic               zero_done_reg, zero_done_next;
  logic [RAM_DEPTH-1:0] row_vld_reg, row_vld_next;

  logic             handshake;
  logic             clear_fire;
  logic             old_vld;
  logic [ROW_W-1:0] old_row;
  logic [ROW_W-1:0] wr_row;
  logic [ROW_W-1:0] rd_row;
  logic [OUT_W-1:0] rq_row;

  assign handshake  = (state_reg == ST_OUT) && dout.dout_ready;
  assign clear_fire = handshake && clear_reg;
  // A clear landing in the same cycle as a write to that row wins: the write overwrites.
  assign old_vld    = row_vld_reg[addra] && !(clear_fire && (ptr_reg == addra));
  assign old_row    = mem[addra];
  assign rd_row     = row_vld_reg[ptr_reg] ? mem[ptr_reg] : '0;

  for (genvar gi = 0; gi < DATA_NUM; gi++) begin : g_lane
    logic [DATA_SIZE-1:0] old_lane;
    logic [DATA_SIZE-1:0] new_lane;
    logic [DATA_SIZE:0]   sum;
    logic [DATA_SIZE-1:0] sat;

    assign old_lane = old_row[gi*DATA_SIZE +: DATA_SIZE];
    assign new_lane = dina[gi*DATA_SIZE +: DATA_SIZE];
    assign sum      = {old_lane[DATA_SIZE-1], old_lane} + {new_lane[DATA_SIZE-1], new_lane};
    assign sat      = (sum[DATA_SIZE] != sum[DATA_SIZE-1])
                      ? (sum[DATA_SIZE] ? ACC_LO : ACC_HI)
                      : sum[DATA_SIZE-1:0];
    assign wr_row[gi*DATA_SIZE +: DATA_SIZE] = (acc_en && old_vld) ? sat : new_lane;

    acc_requant_lane #(
      .DATA_SIZE        (DATA_SIZE),
      .OUTPUT_DATA_SIZE (OUTPUT_DATA_SIZE),
      .SHIFT_W          (SHIFT_W)
    ) u_requant (
      .x    (rd_row[gi*DATA_SIZE +: DATA_SIZE]),
      .s    (shift_reg),
      .relu (relu_reg),
      .y    (rq_row[gi*OUTPUT_DATA_SIZE +: OUTPUT_DATA_SIZE])
    );
  end

  always_ff @(posedge clk) begin
    if (wea) mem[addra] <= wr_row;
  end

  always_comb begin
    row_vld_next = row_vld_reg;
    if (clear_fire) row_vld_next[ptr_reg] = 1'b0;
    if (wea) row_vld_next[addra] = 1'b1;
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    relu_next      = relu_reg;
    clear_next     = clear_reg;
    dout_next      = dout_reg;
    zero_done_next = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (drain_start) begin
          if (drain_len == '0) begin
            zero_done_next = 1'b1;
          end else begin
            ptr_next   = drain_base;
            cnt_next   = drain_len;
            shift_next = shift_amt;
            relu_next  = relu_en;
            clear_next = clear_en;
            state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        dout_next  = rq_row;
        state_next = ST_OUT;
      end
      ST_OUT: begin
        if (dout.dout_ready) begin
          if (cnt_reg == LEN_W'(1)) begin
            state_next = ST_DONE;
          end else begin
            ptr_next   = (ptr_reg == LAST_ROW) ? '0 : ptr_reg + ADDR_W'(1);
            cnt_next   = cnt_reg - LEN_W'(1);
            state_next = ST_READ;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      relu_reg      <= 1'b0;
      clear_reg     <= 1'b0;
      dout_reg      <= '0;
      zero_done_reg <= 1'b0;
      row_vld_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      relu_reg      <= relu_next;
      clear_reg     <= clear_next;
      dout_reg      <= dout_next;
      zero_done_reg <= zero_done_next;
      row_vld_reg   <= row_vld_next;
    end
  end

  assign dout.doutb      = dout_reg;
  assign dout.dout_valid = (state_reg == ST_OUT);
  assign dout.dout_last  = (state_reg == ST_OUT) && (cnt_reg == LEN_W'(1));
  assign busy            = (state_reg != ST_IDLE);
  assign drain_done      = (state_reg == ST_DONE) || zero_done_reg;

endmodule

// File: tb/tb_acc_drain_buffer.sv
// Directed bench for acc_drain_buffer: inputs driven and outputs checked on
// the falling edge, expected rows hand-computed.
module tb_acc_drain_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wea = 1'b0;
  logic         acc_en = 1'b0;
  logic [3:0]   addra = '0;
  logic [319:0] dina = '0;
  logic         drain_start = 1'b0;
  logic [3:0]   drain_base = '0;
  logic [4:0]   drain_len = '0;
  logic [4:0]   shift_amt = '0;
  logic         relu_en = 1'b0;
  logic         clear_en = 1'b0;
  logic         busy;
  logic         drain_done;

  int n_cmp = 0;
  int n_err = 0;

  acc_drain_buffer_if #(.DATA_NUM(16), .OUTPUT_DATA_SIZE(8)) dout_if ();

  acc_drain_buffer #(
    .DATA_SIZE(20), .OUTPUT_DATA_SIZE(8), .DATA_NUM(16), .RAM_DEPTH(16), .SHIFT_W(5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wea         (wea),
    .acc_en      (acc_en),
    .addra       (addra),
    .dina        (dina),
    .drain_start (drain_start),
    .drain_base  (drain_base),
    .drain_len   (drain_len),
    .shift_amt   (shift_amt),
    .relu_en     (relu_en),
    .clear_en    (clear_en),
    .dout        (dout_if),
    .busy        (busy),
    .drain_done  (drain_done)
  );

  always #5 clk = ~clk;

  function automatic logic [319:0] mk_din(input int l0, input int rest);
    logic [319:0] d;
    for (int i = 0; i < 16; i++) d[i*20 +: 20] = (i == 0) ? 20'(l0) : 20'(rest);
    return d;
  endfunction

  function automatic logic [127:0] mk_out(input int l0, input int rest);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = (i == 0) ? 8'(l0) : 8'(rest);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input logic acc, input logic [319:0] d);
    wea = 1'b1; acc_en = acc; addra = 4'(addr); dina = d;
    @(negedge clk);
    wea = 1'b0; acc_en = 1'b0;
  endtask

  task automatic start_drain(input int base, input int len, input int sh,
                             input logic relu, input logic clr);
    drain_start = 1'b1; drain_base = 4'(base); drain_len = 5'(len);
    shift_amt = 5'(sh); relu_en = relu; clear_en = clr;
    @(negedge clk);
    drain_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (dout_if.dout_valid !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(dout_if.dout_valid), 128'(1));
  endtask

  task automatic hs();
    dout_if.dout_ready = 1'b1;
    @(negedge clk);
    dout_if.dout_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dout_if.dout_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", 128'(dout_if.dout_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(drain_done), 128'(0));
    chk("rst_doutb", dout_if.doutb, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Overwrite 100, accumulate 50 twice -> 200 saturates to 127.
    wr(3, 1'b0, mk_din(100, 100));
    wr(3, 1'b1, mk_din(50, 50));
    wr(3, 1'b1, mk_din(50, 50));
    start_drain(3, 1, 0, 1'b0, 1'b0);
    chk("t1_read_busy", 128'(busy), 128'(1));
    chk("t1_read_valid", 128'(dout_if.dout_valid), 128'(0));
    @(negedge clk);
    chk("t1_latency_valid", 128'(dout_if.dout_valid), 128'(1));
    chk("t1_doutb", dout_if.doutb, mk_out(127, 127));
    chk("t1_last", 128'(dout_if.dout_last), 128'(1));
    chk("t1_no_early_done", 128'(drain_done), 128'(0));
    hs();
    chk("t1_done", 128'(drain_done), 128'(1));
    chk("t1_valid_drop", 128'(dout_if.dout_valid), 128'(0));
    @(negedge clk);
    chk("t1_done_pulse", 128'(drain_done), 128'(0));
    chk("t1_idle", 128'(busy), 128'(0));

    // Reset invalidates rows; accumulate onto an invalid row starts from zero.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr(5, 1'b1, mk_din(-7, 0));
    start_drain(5, 1, 1, 1'b0, 1'b0);
    wait_valid("t2_valid");
    chk("t2_round_neg", dout_if.doutb, mk_out(-3, 0));
    hs();
    @(negedge clk);
    start_drain(3, 1, 0, 1'b0, 1'b0);
    wait_valid("t2b_valid");
    chk("t2_row_invalid_after_rst", dout_if.doutb, mk_out(0, 0));
    hs();
    @(negedge clk);

    // Accumulator saturation at 2^19-1, then shift 12 -> 128 -> 127.
    wr(0, 1'b1, mk_din(524287, 0));
    wr(0, 1'b1, mk_din(1, 0));
    start_drain(0, 1, 12, 1'b0, 1'b0);
    wait_valid("t3_valid");
    chk("t3_acc_sat", dout_if.doutb, mk_out(127, 0));
    hs();
    @(negedge clk);

    // Wrapping drain 14,15,0,1 with a 3-cycle stall and writes during the stall.
    wr(14, 1'b0, mk_din(14, 14));
    wr(15, 1'b0, mk_din(15, 15));
    wr(0, 1'b0, mk_din(20, 20));
    wr(1, 1'b0, mk_din(21, 21));
    start_drain(14, 4, 0, 1'b0, 1'b0);
    wait_valid("t4_valid14");
    chk("t4_row14", dout_if.doutb, mk_out(14, 14));
    chk("t4_last14", 128'(dout_if.dout_last), 128'(0));
    hs();
    wait_valid("t4_valid15");
    chk("t4_row15", dout_if.doutb, mk_out(15, 15));
    chk("t4_last15", 128'(dout_if.dout_last), 128'(0));
    wr(15, 1'b1, mk_din(1, 1));
    chk("t4_stall1_hold", dout_if.doutb, mk_out(15, 15));
    chk("t4_stall1_valid", 128'(dout_if.dout_valid), 128'(1));
    wr(0, 1'b0, mk_din(30, 30));
    chk("t4_stall2_hold", dout_if.doutb, mk_out(15, 15));
    @(negedge clk);
    chk("t4_stall3_hold", dout_if.doutb, mk_out(15, 15));
    chk("t4_stall3_valid", 128'(dout_if.dout_valid), 128'(1));
    hs();
    wait_valid("t4_valid0");
    chk("t4_row0_new_write", dout_if.doutb, mk_out(30, 30));
    chk("t4_last0", 128'(dout_if.dout_last), 128'(0));
    hs();
    wait_valid("t4_valid1");
    chk("t4_row1", dout_if.doutb, mk_out(21, 21));
    chk("t4_last1", 128'(dout_if.dout_last), 128'(1));
    hs();
    chk("t4_done", 128'(drain_done), 128'(1));
    @(negedge clk);

    // Clear-on-read with ReLU and rounding shift.
    wr(2, 1'b0, mk_din(-40, 40));
    start_drain(2, 1, 2, 1'b1, 1'b1);
    wait_valid("t5_valid");
    chk("t5_relu_shift", dout_if.doutb, mk_out(0, 10));
    hs();
    @(negedge clk);
    start_drain(2, 1, 2, 1'b1, 1'b0);
    wait_valid("t5b_valid");
    chk("t5_cleared", dout_if.doutb, mk_out(0, 0));
    hs();
    @(negedge clk);
    wr(2, 1'b0, mk_din(40, 40));
    start_drain(2, 1, 0, 1'b0, 1'b1);
    wait_valid("t5c_valid");
    chk("t5c_row", dout_if.doutb, mk_out(40, 40));
    dout_if.dout_ready = 1'b1;
    wea = 1'b1; acc_en = 1'b1; addra = 4'd2; dina = mk_din(5, 5);
    @(negedge clk);
    dout_if.dout_ready = 1'b0;
    wea = 1'b0; acc_en = 1'b0;
    @(negedge clk);
    start_drain(2, 1, 0, 1'b0, 1'b0);
    wait_valid("t5d_valid");
    chk("t5_write_vs_clear", dout_if.doutb, mk_out(5, 5));
    hs();
    @(negedge clk);

    // Asynchronous reset during OUT, then a zero-length drain.
    start_drain(2, 1, 0, 1'b0, 1'b0);
    wait_valid("t6_valid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 128'(dout_if.dout_valid), 128'(0));
    chk("t6_async_busy", 128'(busy), 128'(0));
    chk("t6_async_doutb", dout_if.doutb, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_drain(0, 0, 0, 1'b0, 1'b0);
    chk("t6_len0_done", 128'(drain_done), 128'(1));
    chk("t6_len0_valid", 128'(dout_if.dout_valid), 128'(0));
    chk("t6_len0_busy", 128'(busy), 128'(0));
    @(negedge clk);
    chk("t6_len0_pulse", 128'(drain_done), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acc_drain_buffer.md
Name: acc_drain_buffer

Overview:
Next-generation output accumulator for the systolic array. It holds RAM_DEPTH rows of DATA_NUM signed partial sums, each DATA_SIZE bits wide, and applies saturating accumulate or overwrite on writes. A drain engine streams a contiguous range of rows to the unified buffer over a valid/ready interface. Each lane is requantised (rounding right shift, optional ReLU, saturation to OUTPUT_DATA_SIZE), and each row can optionally be cleared once it has been read.

Parameters:
DATA_SIZE, 20, accumulator lane width (signed)
OUTPUT_DATA_SIZE, 8, output lane width (signed)
DATA_NUM, 16, lanes per row
RAM_DEPTH, 16, rows; any value >= 2
SHIFT_W, 5, width of shift_amt
ADDR_W, clogb2(RAM_DEPTH-1), row address width (from shared header)
LEN_W, clogb2(RAM_DEPTH), drain length width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wea  in  1  write strobe
acc_en  in  1  1 = accumulate onto row, 0 = overwrite row
addra  in  ADDR_W  write row
dina  in  DATA_NUM*DATA_SIZE  write data, lane i at [i*DATA_SIZE +: DATA_SIZE]
drain_start  in  1  start pulse, sampled only in IDLE
drain_base  in  ADDR_W  first row to drain
drain_len  in  LEN_W  row count, 1..RAM_DEPTH
shift_amt  in  SHIFT_W  requant right shift, 0..DATA_SIZE-1
relu_en  in  1  clamp negative lanes to 0
clear_en  in  1  invalidate each row after its output handshake
doutb  out  DATA_NUM*OUTPUT_DATA_SIZE  requantised row
dout_valid  out  1  doutb valid
dout_ready  in  1  consumer ready
dout_last  out  1  asserted with the final row of the drain
busy  out  1  drain FSM not in IDLE
drain_done  out  1  one-cycle pulse at drain end

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE. dout_valid, dout_last, busy and drain_done are 0. doutb is 0. row_vld[RAM_DEPTH-1:0] is 0. BRAM contents are not reset.
- row_vld: a row with row_vld=0 reads as all-zero lanes for both accumulate and drain. Any write sets row_vld[addra]=1.
- Write, same cycle (one-cycle write):
  - acc_en=0: stores dina.
  - acc_en=1: each lane stores sat_DATA_SIZE(old + dina), computed at DATA_SIZE+1 bits and clamped to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
- Back-to-back accumulates to the same row must be correct every cycle. The read-modify-write is a single cycle on registered storage, with no forwarding hazard.
- FSM states:
  - IDLE: on drain_start with drain_len=0, pulse drain_done the next cycle and stay in IDLE. On drain_start with drain_len>0, latch base, len, shift_amt, relu_en and clear_en, set ptr=base and cnt=len, then go to READ.
  - READ (1 cycle): capture the row at ptr into an output register with requantisation applied. Go to OUT.
  - OUT: dout_valid=1; doutb and dout_last (cnt==1) are held stable until dout_ready. On handshake:
    - If clear_en, clear row_vld[ptr].
    - If cnt==1, go to DONE.
    - Otherwise ptr=(ptr+1) mod RAM_DEPTH, cnt--, go to READ.
  - DONE: drain_done=1 for one cycle, then go to IDLE.
- Throughput: 2 cycles per row minimum. The first dout_valid appears 2 cycles after drain_start.
- drain_start while busy is ignored.
- Requant per lane:
  - If s>0: y = (x + 2^(s-1)) >>> s, computed at DATA_SIZE+1 bits. If s=0: y = x.
  - If relu then y = max(y, 0).
  - Saturate y to [-2^(OUTPUT_DATA_SIZE-1), 2^(OUTPUT_DATA_SIZE-1)-1].
- Address wrap: base+len beyond RAM_DEPTH-1 wraps to row 0. len=RAM_DEPTH drains every row exactly once.
- Write concurrent with drain:
  - A write to the row held in OUT does not alter doutb.
  - A write to a not-yet-read row is visible when that row is read.
  - A write in the same cycle as a clearing handshake on the same row: clear applies first, so the row becomes dina (acc_en ignored) and row_vld=1.
- Reset mid-drain: output drops immediately and the FSM returns to IDLE. Partial clears already performed persist (row_vld is reset anyway).

Decomposition:
- Shared header sa_share.v: clogb2; lane min/max constants; FSM state encodings ST_IDLE, ST_READ, ST_OUT, ST_DONE.
- One sub-module, acc_requant_lane: combinational shift/round/ReLU/saturate for one lane. Instantiated DATA_NUM times by generate. The FSM, storage and row_vld stay in the top level.

Test Plan:
- Overwrite row 3 with all lanes 100, then accumulate 50 twice. Drain base=3, len=1, shift=0 -> lanes 127 (saturated from 200), dout_last=1, drain_done pulses after the handshake.
- After reset, accumulate row 5 with lane0=-7 and no prior overwrite. Drain shift=1, relu=0 -> lane0=-3 (round half up of -3.5), other lanes 0.
- Accumulate row 0 lane0 = 2^19-1, then accumulate +1 -> stored 524287 (no wrap). Drain shift=12 -> 127 (saturated).
- Drain base=14, len=4 on RAM_DEPTH=16, with dout_ready low 3 cycles on the second row -> rows 14, 15, 0, 1 in order. doutb is held stable while stalled. dout_last only on row 1.
- clear_en=1, relu=1, row 2 lanes -40/+40, shift=2 -> 0/10. A second drain of row 2 -> all 0. A write to row 2 in the clearing handshake cycle -> a later drain shows dina.
- Assert rst_n low mid-drain during OUT -> dout_valid and busy go 0 asynchronously. After release, drain_len=0 with drain_start -> drain_done the next cycle, no dout_valid.
